// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit:
// FSM states, major opcodes and datapath select values.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: legality, immediate format,
// ALU operand sources and writeback source for the current instruction.
module ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       legal,
    output logic [2:0] imm_sel,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [1:0] wb_sel,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jal,
    output logic       is_jalr
);

    always_comb begin
        legal     = 1'b1;
        imm_sel   = IMM_I;
        alu_src_a = 1'b0;
        alu_src_b = 1'b1;
        wb_sel    = WB_ALU;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        unique case (opcode)
            OPC_OP:     alu_src_b = 1'b0;
            OPC_OP_IMM: ;
            OPC_LOAD: begin
                is_load = 1'b1;
                wb_sel  = WB_MEM;
            end
            OPC_STORE: begin
                is_store = 1'b1;
                imm_sel  = IMM_S;
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                imm_sel   = IMM_B;
                alu_src_a = 1'b1;
            end
            OPC_JAL: begin
                is_jal    = 1'b1;
                imm_sel   = IMM_J;
                alu_src_a = 1'b1;
                wb_sel    = WB_PC4;
            end
            OPC_JALR: begin
                is_jalr = 1'b1;
                wb_sel  = WB_PC4;
            end
            OPC_LUI:    imm_sel = IMM_U;
            OPC_AUIPC: begin
                imm_sel   = IMM_U;
                alu_src_a = 1'b1;
            end
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with a
// retired-instruction counter; opcode classification lives in ctrl_decode.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [2:0]  imm_sel,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] instret
);

    state_e      state_q, state_d;
    logic [31:0] instret_q, instret_d;

    logic       dec_legal, dec_a, dec_b;
    logic [2:0] dec_imm;
    logic [1:0] dec_wb;
    logic       is_load, is_store, is_branch, is_jal, is_jalr;

    logic unused_inst_bits;
    assign unused_inst_bits = ^inst[31:7];

    ctrl_decode u_decode (
        .opcode    (inst[6:0]),
        .legal     (dec_legal),
        .imm_sel   (dec_imm),
        .alu_src_a (dec_a),
        .alu_src_b (dec_b),
        .wb_sel    (dec_wb),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_branch (is_branch),
        .is_jal    (is_jal),
        .is_jalr   (is_jalr)
    );

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = PC_PLUS4;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        imm_sel   = dec_imm;
        unique case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                alu_src_a = dec_a;
                alu_src_b = dec_b;
                if (is_branch) begin
                    pc_write = 1'b1;
                    pc_sel   = br_taken ? PC_IMM : PC_PLUS4;
                    state_d  = ST_FETCH;
                end else if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                alu_src_a = dec_a;
                alu_src_b = dec_b;
                mem_req   = 1'b1;
                mem_we    = is_store;
                if (mem_ready) begin
                    pc_write = is_store;
                    state_d  = is_store ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                alu_src_a = dec_a;
                alu_src_b = dec_b;
                reg_write = 1'b1;
                pc_write  = 1'b1;
                wb_sel    = dec_wb;
                pc_sel    = is_jal ? PC_IMM : (is_jalr ? PC_ALU : PC_PLUS4);
                state_d   = ST_FETCH;
            end
            ST_TRAP: ;
            default: state_d = ST_FETCH;
        endcase
        // Reset is asynchronous, so strobes must also drop combinationally
        // while it is held; mem_req keeps its FETCH value.
        if (rst) begin
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_sel    = PC_PLUS4;
            reg_write = 1'b0;
            wb_sel    = WB_ALU;
            alu_src_a = 1'b0;
            alu_src_b = 1'b0;
            imm_sel   = '0;
        end
    end

    assign instret_d = instret_q + {31'd0, pc_write};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign state   = state_q;
    assign illegal = (state_q == ST_TRAP);
    assign instret = instret_q;

endmodule
